// File: rtl/csa_reduce_pipe.sv
// Pipelined multi-operand adder: 4:2 compressor levels, register per level, optional registered CPA.
// Latency S = levels (+1 with CPA); valid/ready with bubble collapsing, stalled stages hold data and tag.
module csa_reduce_pipe #(
  parameter  int WIDTH   = 32,
  parameter  int NUM_OPS = 8,
  parameter  int OUT_CS  = 0,
  parameter  int TAG_W   = 4,
  localparam int OW      = WIDTH + $clog2(NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_signed,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OW-1:0]            out_sum,
  output logic [OW-1:0]            out_carry,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int L = $clog2(NUM_OPS) - 1;
  localparam int S = L + ((OUT_CS != 0) ? 0 : 1);

  if (NUM_OPS != 4 && NUM_OPS != 8 && NUM_OPS != 16) begin : g_bad_ops
    $fatal(1, "csa_reduce_pipe: NUM_OPS must be 4, 8 or 16");
  end
  if (WIDTH < 4) begin : g_bad_width
    $fatal(1, "csa_reduce_pipe: WIDTH must be at least 4");
  end
  if (OUT_CS != 0 && OUT_CS != 1) begin : g_bad_outcs
    $fatal(1, "csa_reduce_pipe: OUT_CS must be 0 or 1");
  end

  logic [S-1:0]     v;
  logic [S-1:0]     rdy;
  logic [S-1:0]     vin;
  logic             in_fire;
  logic [TAG_W-1:0] tag_q [S];
  logic [TAG_W-1:0] tin   [S];

  // A stage is ready when any stage from it to the output holds a bubble, or the consumer takes data.
  always_comb begin
    logic all_v;
    rdy = '0;
    for (int s = 0; s < S; s++) begin
      all_v = 1'b1;
      for (int t = s; t < S; t++) begin
        all_v = all_v & v[t];
      end
      rdy[s] = out_ready | ~all_v;
    end
  end

  assign in_ready = rdy[0];
  assign in_fire  = in_valid & rdy[0];

  always_comb begin
    vin    = '0;
    vin[0] = in_fire;
    tin[0] = in_tag;
    for (int s = 1; s < S; s++) begin
      vin[s] = v[s-1];
      tin[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int s = 0; s < S; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < S; s++) begin
        if (flush) begin
          v[s] <= 1'b0;
        end else if (rdy[s]) begin
          v[s] <= vin[s];
        end
        if (rdy[s]) begin
          tag_q[s] <= tin[s];
        end
      end
    end
  end

  for (genvar g = 0; g < L; g++) begin : g_lvl
    localparam int NI = NUM_OPS >> g;
    localparam int NO = NI / 2;

    logic [OW-1:0] din [NI];
    logic [OW-1:0] nxt [NO];
    logic [OW-1:0] q   [NO];

    if (g == 0) begin : g_ext
      always_comb begin
        for (int k = 0; k < NI; k++) begin
          din[k] = {{(OW-WIDTH){in_signed & in_ops[k*WIDTH+WIDTH-1]}}, in_ops[k*WIDTH +: WIDTH]};
        end
      end
    end else begin : g_chain
      always_comb begin
        for (int k = 0; k < NI; k++) begin
          din[k] = g_lvl[g-1].q[k];
        end
      end
    end

    // Row of 4:2 cells; cout of bit i feeds cin of bit i+1, top cout and top carry drop out (mod 2^OW).
    always_comb begin
      logic [OW-1:0] s1, co, ci, cy;
      s1 = '0;
      co = '0;
      ci = '0;
      cy = '0;
      for (int j = 0; j < NI / 4; j++) begin
        s1 = din[4*j] ^ din[4*j+1] ^ din[4*j+2];
        co = (din[4*j] & din[4*j+1]) | (din[4*j] & din[4*j+2]) | (din[4*j+1] & din[4*j+2]);
        ci = co << 1;
        cy = (s1 & din[4*j+3]) | (s1 & ci) | (din[4*j+3] & ci);
        nxt[2*j]   = s1 ^ din[4*j+3] ^ ci;
        nxt[2*j+1] = cy << 1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < NO; k++) begin
          q[k] <= '0;
        end
      end else if (rdy[g]) begin
        for (int k = 0; k < NO; k++) begin
          q[k] <= nxt[k];
        end
      end
    end
  end

  if (OUT_CS == 0) begin : g_cpa
    logic [OW-1:0] sum_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
      end else if (rdy[L]) begin
        sum_q <= g_lvl[L-1].q[0] + g_lvl[L-1].q[1];
      end
    end
    assign out_sum   = sum_q;
    assign out_carry = '0;
  end else begin : g_cs
    assign out_sum   = g_lvl[L-1].q[0];
    assign out_carry = g_lvl[L-1].q[1];
  end

  assign out_valid = v[S-1];
  assign out_tag   = tag_q[S-1];

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// Directed and model-checked bench for csa_reduce_pipe: CPA build (8 ops) and carry-save builds (16 and 4 ops).
module tb_csa_reduce_pipe;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_signed, out_ready;
  logic [511:0] in_ops;
  logic [3:0]   in_tag;

  logic        ir8, ov8, ir16, ov16, ir4, ov4;
  logic [34:0] sum8, carry8;
  logic [35:0] sum16, carry16, cs16;
  logic [33:0] sum4, carry4, cs4;
  logic [3:0]  tag8, tag16, tag4;

  always #5 clk = ~clk;

  csa_reduce_pipe #(.WIDTH(32), .NUM_OPS(8), .OUT_CS(0), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
    .in_signed(in_signed), .in_ops(in_ops[255:0]), .in_tag(in_tag), .out_valid(ov8),
    .out_ready(out_ready), .out_sum(sum8), .out_carry(carry8), .out_tag(tag8));

  csa_reduce_pipe #(.WIDTH(32), .NUM_OPS(16), .OUT_CS(1), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir16),
    .in_signed(in_signed), .in_ops(in_ops), .in_tag(in_tag), .out_valid(ov16),
    .out_ready(out_ready), .out_sum(sum16), .out_carry(carry16), .out_tag(tag16));

  csa_reduce_pipe #(.WIDTH(32), .NUM_OPS(4), .OUT_CS(1), .TAG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .in_signed(in_signed), .in_ops(in_ops[127:0]), .in_tag(in_tag), .out_valid(ov4),
    .out_ready(out_ready), .out_sum(sum4), .out_carry(carry4), .out_tag(tag4));

  assign cs16 = sum16 + carry16;
  assign cs4  = sum4 + carry4;

  // Instance under test: 0 = 8-op CPA, 1 = 16-op carry-save, 2 = 4-op carry-save.
  int          sel;
  logic        m_ir, m_ov;
  logic [3:0]  m_tag;
  logic [63:0] m_res;
  int          m_s, m_n, m_ow;

  always_comb begin
    m_ir = ir8; m_ov = ov8; m_tag = tag8; m_res = 64'(sum8); m_s = 3; m_n = 8; m_ow = 35;
    case (sel)
      1: begin m_ir = ir16; m_ov = ov16; m_tag = tag16; m_res = 64'(cs16); m_s = 3; m_n = 16; m_ow = 36; end
      2: begin m_ir = ir4;  m_ov = ov4;  m_tag = tag4;  m_res = 64'(cs4);  m_s = 1; m_n = 4;  m_ow = 34; end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] fill(input int n, input logic [31:0] val);
    logic [511:0] r = '0;
    for (int k = 0; k < n; k++) r[k*32 +: 32] = val;
    return r;
  endfunction

  function automatic logic [63:0] model(input logic [511:0] ops, input logic sg, input int n, input int ow);
    logic [63:0] acc = '0;
    logic [63:0] e;
    for (int k = 0; k < n; k++) begin
      e = {32'b0, ops[k*32 +: 32]};
      if (sg && ops[k*32+31]) e[63:32] = '1;
      acc = acc + e;
    end
    return acc & ((64'd1 << ow) - 64'd1);
  endfunction

  task automatic one(input logic [511:0] ops, input logic sg, input logic [3:0] tg,
                     input logic [63:0] exp, input string name);
    int lat;
    @(negedge clk);
    in_ops = ops; in_signed = sg; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({name, "_rdy"}, 64'(m_ir), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!m_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(m_s));
    chk({name, "_sum"}, m_res, exp);
    chk({name, "_tag"}, 64'(m_tag), 64'(tg));
  endtask

  task automatic stream(input int n, input int st_start, input int st_len, input int exp_fill);
    logic [63:0]  q_res[$];
    logic [3:0]   q_tag[$];
    logic [511:0] ops = '0;
    logic         sg = 1'b0;
    logic         have = 1'b0, stalled = 1'b0;
    logic [63:0]  hold_res = '0;
    logic [3:0]   hold_tag = '0;
    int sent = 0, got = 0, cyc = 0, fills = 0;
    int first_in = -1, first_out = -1, last_out = -1;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      out_ready = !(cyc >= st_start && cyc < st_start + st_len);
      if (!have && sent < n) begin
        for (int k = 0; k < 16; k++) ops[k*32 +: 32] = $urandom;
        sg = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      in_valid = have; in_ops = ops; in_signed = sg; in_tag = 4'(sent);
      #1;
      if (stalled) begin
        chk("stall_res", m_res, hold_res);
        chk("stall_tag", 64'(m_tag), 64'(hold_tag));
      end
      stalled  = m_ov && !out_ready;
      hold_res = m_res;
      hold_tag = m_tag;
      if (m_ov && out_ready) begin
        if (q_res.size() == 0) begin
          chk("spurious_out", 64'(m_ov), 64'd0);
        end else begin
          chk("stream_res", m_res, q_res.pop_front());
          chk("stream_tag", 64'(m_tag), 64'(q_tag.pop_front()));
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      if (in_valid && m_ir) begin
        q_res.push_back(model(ops, sg, m_n, m_ow));
        q_tag.push_back(4'(sent));
        if (first_in < 0) first_in = cyc;
        if (!out_ready) fills++;
        sent++;
        have = 1'b0;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 64'(got), 64'(n));
    if (st_start > m_s) begin
      chk("stream_lat", 64'(first_out - first_in), 64'(m_s));
      chk("stream_span", 64'(last_out - first_out), 64'(n - 1 + st_len));
    end
    if (exp_fill >= 0) chk("stall_accepts", 64'(fills), 64'(exp_fill));
  endtask

  task automatic do_flush(input string name);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk(name, 64'(m_ov), 64'd0);
  endtask

  initial begin
    logic [511:0] sv;
    sel = 0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_ops = '0; in_tag = '0; out_ready = 1'b1;
    #12;
    chk("rst_ov", 64'(m_ov), 64'd0);
    chk("rst_sum", m_res, 64'd0);
    chk("rst_tag", 64'(m_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ir", 64'(m_ir), 64'd1);
    chk("carry_tied", 64'(carry8), 64'd0);

    sv = '0;
    sv[31:0] = 32'hFFFF_FFFF; sv[63:32] = 32'hFFFF_FFFE; sv[95:64] = 32'd3; sv[255:224] = 32'h7FFF_FFFF;
    one(fill(8, 32'hFFFF_FFFF), 1'b0, 4'd5, 64'h7_FFFF_FFF8, "ones_u");
    one(sv, 1'b1, 4'd9, 64'h0_7FFF_FFFF, "vec_s");
    one(sv, 1'b0, 4'd10, 64'h2_7FFF_FFFF, "vec_u");
    one(fill(4, 32'h8000_0000), 1'b1, 4'd3, 64'h6_0000_0000, "half_s");
    one(fill(4, 32'h8000_0000), 1'b0, 4'd12, 64'h2_0000_0000, "half_u");

    stream(20, 1000, 0, -1);
    stream(12, 0, 6, 3);
    stream(15, 5, 6, 0);

    // Flush with two in flight and a third presented on the flush cycle.
    @(negedge clk); in_ops = fill(8, 32'd1); in_tag = 4'd1; in_valid = 1'b1;
    @(negedge clk); in_tag = 4'd2;
    @(negedge clk); in_tag = 4'd3; flush = 1'b1;
    #1 chk("flush_ir", 64'(m_ir), 64'd1);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    chk("flush_ov", 64'(m_ov), 64'd0);
    repeat (4) @(negedge clk);
    chk("flush_drop", 64'(m_ov), 64'd0);
    one(fill(8, 32'd7), 1'b0, 4'd4, 64'd56, "post_flush");

    // Reset while a result sits on the output.
    @(negedge clk); in_ops = fill(8, 32'hFFFF_FFFF); in_tag = 4'd6; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ov", 64'(m_ov), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(m_ov), 64'd0);
    chk("mid_rst_sum", m_res, 64'd0);
    chk("mid_rst_tag", 64'(m_tag), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("mid_rst_ir", 64'(m_ir), 64'd1);
    one(fill(8, 32'h0000_0010), 1'b1, 4'd8, 64'h80, "post_rst");

    sel = 1;
    do_flush("flush16");
    one(fill(16, 32'hFFFF_FFFF), 1'b1, 4'd9, 64'hF_FFFF_FFF0, "cs16_ones");
    stream(20, 1000, 0, -1);

    sel = 2;
    do_flush("flush4");
    one(fill(4, 32'h7FFF_FFFF), 1'b1, 4'd3, 64'h1_FFFF_FFFC, "cs4_max");
    stream(20, 1000, 0, -1);
    stream(10, 4, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
